// File: rtl/expr_pkg.sv
// Shared types and constants for the expression evaluator.
//   state_e : evaluator FSM states
//   op_e    : operator code produced by the character classifier
//   CH_*    : ASCII codes for the recognised characters
package expr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // nothing consumed since clear
    NUM  = 2'd1,  // last character was a digit
    OP   = 2'd2,  // last character was an operator
    ERR  = 2'd3   // malformed input seen, sticky until clear
  } state_e;

  typedef enum logic [1:0] {
    ADD = 2'd0,
    SUB = 2'd1,
    MUL = 2'd2,
    BAD = 2'd3    // not an operator (digit or illegal byte)
  } op_e;

  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;
  localparam logic [7:0] CH_PLUS  = 8'h2B;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_STAR  = 8'h2A;

endpackage

// File: rtl/expr_eval_if.sv
// Character-stream bus between the producer and the expression evaluator.
//   in       : ASCII character
//   in_valid : character is consumed at this edge
//   ok       : consumed prefix is a complete expression
//   err      : consumed prefix is malformed (sticky)
//   result   : value of the prefix through its last digit
interface expr_eval_if #(
  parameter int WIDTH = 16
);
  logic [7:0]       in;
  logic             in_valid;
  logic             ok;
  logic             err;
  logic [WIDTH-1:0] result;

  modport master (
    output in, in_valid,
    input  ok, err, result
  );

  modport slave (
    input  in, in_valid,
    output ok, err, result
  );
endinterface

// File: rtl/expr_eval_char_class.sv
// Purely combinational character classifier.
//   in_i       : ASCII character
//   is_digit_o : character is '0'..'9'
//   digit_o    : numeric value of the digit (0 when not a digit)
//   op_o       : operator code, BAD for anything that is not + - *
module char_class
  import expr_pkg::*;
(
  input  logic [7:0] in_i,
  output logic       is_digit_o,
  output logic [3:0] digit_o,
  output op_e        op_o
);

  always_comb begin
    is_digit_o = (in_i >= CH_0) && (in_i <= CH_9);
    // '0'..'9' are 0x30..0x39, so the low nibble is the value.
    digit_o    = is_digit_o ? in_i[3:0] : 4'd0;
    case (in_i)
      CH_PLUS:  op_o = ADD;
      CH_MINUS: op_o = SUB;
      CH_STAR:  op_o = MUL;
      default:  op_o = BAD;
    endcase
  end

endmodule

// File: rtl/expr_eval.sv
// Streaming single-digit expression evaluator with * precedence over + / -.
//   clk : system clock
//   clr : synchronous active-high clear, overrides any input character
//   bus : expr_eval_if slave (in, in_valid -> ok, err, result)
// State is a running sum of completed additive terms plus the current signed
// product term; result is sum+term, refreshed only when a digit is consumed.
module expr_eval
  import expr_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic        clk,
  input logic        clr,
  expr_eval_if.slave bus
);

  logic             is_digit;
  logic [3:0]       digit;
  op_e              op;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] term_q, term_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             neg_q, neg_d;
  logic             mul_q, mul_d;

  logic [WIDTH-1:0] digit_w;
  logic [WIDTH-1:0] prod;
  logic [WIDTH-1:0] term_new;
  logic [WIDTH-1:0] add_a, add_b, add_res;

  char_class u_cls (
    .in_i       (bus.in),
    .is_digit_o (is_digit),
    .digit_o    (digit),
    .op_o       (op)
  );

  // Datapath: one multiplier, one adder shared between "close the term on
  // +/-" (sum+term) and "refresh result on a digit" (sum'+term').
  always_comb begin
    digit_w  = {{(WIDTH-4){1'b0}}, digit};
    prod     = term_q * digit_w;
    if (state_q == IDLE)  term_new = digit_w;
    else if (mul_q)       term_new = prod;
    else if (neg_q)       term_new = '0 - digit_w;
    else                  term_new = digit_w;
    // A fresh expression starts from an empty sum.
    add_a    = (state_q == IDLE) ? '0 : sum_q;
    add_b    = is_digit ? term_new : term_q;
    add_res  = add_a + add_b;
  end

  always_comb begin
    state_d  = state_q;
    sum_d    = sum_q;
    term_d   = term_q;
    result_d = result_q;
    neg_d    = neg_q;
    mul_d    = mul_q;
    if (bus.in_valid) begin
      case (state_q)
        IDLE: begin
          if (is_digit) begin
            state_d  = NUM;
            sum_d    = '0;
            term_d   = term_new;
            result_d = add_res;
          end else begin
            state_d  = ERR;
          end
        end
        NUM: begin
          if (op == BAD) begin
            state_d = ERR;
          end else begin
            state_d = OP;
            if (op == MUL) begin
              mul_d = 1'b1;
            end else begin
              sum_d = add_res;
              mul_d = 1'b0;
              neg_d = (op == SUB);
            end
          end
        end
        OP: begin
          if (is_digit) begin
            state_d  = NUM;
            term_d   = term_new;
            result_d = add_res;
          end else begin
            state_d  = ERR;
          end
        end
        default: ; // ERR absorbs everything until clear
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= IDLE;
      sum_q    <= '0;
      term_q   <= '0;
      result_q <= '0;
      neg_q    <= 1'b0;
      mul_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sum_q    <= sum_d;
      term_q   <= term_d;
      result_q <= result_d;
      neg_q    <= neg_d;
      mul_q    <= mul_d;
    end
  end

  // Pure decodes of registered state; no input-to-output path.
  assign bus.ok     = (state_q == NUM);
  assign bus.err    = (state_q == ERR);
  assign bus.result = result_q;

endmodule

// File: tb/tb_expr_eval.sv
module tb_expr_eval;
  import expr_pkg::*;

  logic clk;
  logic clr;

  expr_eval_if #(.WIDTH(16)) if16 ();
  expr_eval_if #(.WIDTH(8))  if8 ();

  expr_eval #(.WIDTH(16)) dut16 (.clk(clk), .clr(clr), .bus(if16));
  expr_eval #(.WIDTH(8))  dut8  (.clk(clk), .clr(clr), .bus(if8));

  int checks = 0;
  int errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- reference model: whole-prefix re-evaluation -------------
  logic [7:0] m_str[$];
  bit         m_err;
  longint     m_res;

  function automatic bit is_dig(logic [7:0] c);
    return (c >= "0") && (c <= "9");
  endfunction

  function automatic bit is_op(logic [7:0] c);
    return (c == "+") || (c == "-") || (c == "*");
  endfunction

  // Evaluates the accepted prefix (always ends in a digit) with ordinary
  // precedence; 64-bit wrap is harmless because only low bits are compared.
  function automatic longint m_eval();
    longint total, cur, d;
    total = 0;
    cur   = longint'(m_str[0]) - 48;
    for (int i = 1; i + 1 < m_str.size(); i += 2) begin
      d = longint'(m_str[i+1]) - 48;
      if (m_str[i] == "*") cur = cur * d;
      else begin
        total = total + cur;
        cur   = (m_str[i] == "-") ? -d : d;
      end
    end
    return total + cur;
  endfunction

  function automatic void model_step(bit c, bit v, logic [7:0] ch);
    bit legal;
    if (c) begin
      m_str.delete();
      m_err = 0;
      m_res = 0;
    end else if (v && !m_err) begin
      if (m_str.size() == 0)       legal = is_dig(ch);
      else if (is_dig(m_str[$]))   legal = is_op(ch);
      else                         legal = is_dig(ch);
      if (!legal) m_err = 1;
      else begin
        m_str.push_back(ch);
        if (is_dig(ch)) m_res = m_eval();
      end
    end
  endfunction

  function automatic bit m_ok();
    return !m_err && (m_str.size() > 0) && is_dig(m_str[$]);
  endfunction

  // ---------------- drive / check ----------------
  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(bit c, bit v, logic [7:0] ch);
    @(negedge clk);
    clr           = c;
    if16.in_valid = v;
    if16.in       = ch;
    if8.in_valid  = v;
    if8.in        = ch;
    @(posedge clk);
    #1;
    model_step(c, v, ch);
  endtask

  typedef struct {
    bit         c;
    bit         v;
    logic [7:0] ch;
    bit         chk;
    bit         eok;
    bit         eerr;
    logic [15:0] r16;
    logic [7:0]  r8;
  } vec_t;

  vec_t tbl[$];

  function automatic void row(bit c, bit v, logic [7:0] ch, bit chk,
                              bit eok = 0, bit eerr = 0,
                              logic [15:0] r16 = 0, logic [7:0] r8 = 0);
    vec_t t;
    t.c = c; t.v = v; t.ch = ch; t.chk = chk;
    t.eok = eok; t.eerr = eerr; t.r16 = r16; t.r8 = r8;
    tbl.push_back(t);
  endfunction

  function automatic void dig(logic [7:0] ch);
    row(0, 1, ch, 0);
  endfunction

  initial begin
    clr = 1'b1;
    if16.in_valid = 1'b0; if16.in = 8'h00;
    if8.in_valid  = 1'b0; if8.in  = 8'h00;
    m_err = 0; m_res = 0;

    // reset state, then 1+2*3
    row(1, 0, 8'h00, 1, 0, 0, 16'd0, 8'd0);
    row(0, 1, "1", 1, 1, 0, 16'd1, 8'd1);
    row(0, 1, "+", 1, 0, 0, 16'd1, 8'd1);
    dig("2"); dig("*");
    row(0, 1, "3", 1, 1, 0, 16'd7, 8'd7);
    // 9-2*4-5 = -4
    row(1, 0, 8'h00, 0);
    dig("9"); dig("-"); dig("2"); dig("*"); dig("4"); dig("-");
    row(0, 1, "5", 1, 1, 0, 16'hFFFC, 8'hFC);
    // 9^4 = 6561 wraps at 8 bits
    row(1, 0, 8'h00, 0);
    dig("9"); dig("*"); dig("9"); dig("*"); dig("9"); dig("*");
    row(0, 1, "9", 1, 1, 0, 16'h19A1, 8'hA1);
    // two digits in a row, later input ignored
    row(1, 0, 8'h00, 0);
    dig("1");
    row(0, 1, "2", 1, 0, 1, 16'd1, 8'd1);
    dig("+");
    row(0, 1, "3", 1, 0, 1, 16'd1, 8'd1);
    // leading operator
    row(1, 0, 8'h00, 0);
    row(0, 1, "+", 1, 0, 1, 16'd0, 8'd0);
    // double operator
    row(1, 0, 8'h00, 0);
    dig("3"); dig("+");
    row(0, 1, "*", 1, 0, 1, 16'd3, 8'd3);
    // illegal byte
    row(1, 0, 8'h00, 0);
    dig("4");
    row(0, 1, "x", 1, 0, 1, 16'd4, 8'd4);
    // clear recovers
    row(1, 0, 8'h00, 1, 0, 0, 16'd0, 8'd0);
    row(0, 1, "5", 1, 1, 0, 16'd5, 8'd5);
    // bubbles hold everything
    row(1, 0, 8'h00, 0);
    row(0, 1, "2", 1, 1, 0, 16'd2, 8'd2);
    row(0, 0, "+", 1, 1, 0, 16'd2, 8'd2);
    row(0, 0, "*", 1, 1, 0, 16'd2, 8'd2);
    row(0, 0, "x", 1, 1, 0, 16'd2, 8'd2);
    dig("*");
    row(0, 1, "7", 1, 1, 0, 16'd14, 8'd14);
    // clear beats a valid character mid-expression
    row(1, 0, 8'h00, 0);
    dig("6"); dig("+");
    row(1, 1, "8", 1, 0, 0, 16'd0, 8'd0);
    row(0, 1, "3", 1, 1, 0, 16'd3, 8'd3);

    foreach (tbl[i]) begin
      apply(tbl[i].c, tbl[i].v, tbl[i].ch);
      if (tbl[i].chk) begin
        check($sformatf("vec%0d ok16", i),  {15'd0, if16.ok},  {15'd0, tbl[i].eok});
        check($sformatf("vec%0d err16", i), {15'd0, if16.err}, {15'd0, tbl[i].eerr});
        check($sformatf("vec%0d res16", i), if16.result,       tbl[i].r16);
        check($sformatf("vec%0d ok8", i),   {15'd0, if8.ok},   {15'd0, tbl[i].eok});
        check($sformatf("vec%0d err8", i),  {15'd0, if8.err},  {15'd0, tbl[i].eerr});
        check($sformatf("vec%0d res8", i),  {8'd0, if8.result}, {8'd0, tbl[i].r8});
      end
    end

    // randomized stream against the model
    apply(1, 0, 8'h00);
    for (int n = 0; n < 3000; n++) begin
      bit         c, v, want_dig;
      logic [7:0] ch;
      int         r;
      c = ($urandom_range(0, 99) < 4);
      v = ($urandom_range(0, 99) < 80);
      want_dig = (m_str.size() == 0) || !is_dig(m_str[$]);
      r = $urandom_range(0, 99);
      if (r < 88) begin
        if (want_dig) ch = CH_0 + 8'($urandom_range(0, 9));
        else case ($urandom_range(0, 2))
          0:       ch = CH_PLUS;
          1:       ch = CH_MINUS;
          default: ch = CH_STAR;
        endcase
      end else if (r < 94) begin
        ch = want_dig ? CH_STAR : CH_0 + 8'($urandom_range(0, 9));
      end else begin
        ch = 8'($urandom_range(0, 255));
        if (is_dig(ch) || is_op(ch)) ch = "x";
      end
      apply(c, v, ch);
      check("rnd ok16",  {15'd0, if16.ok},   {15'd0, m_ok()});
      check("rnd err16", {15'd0, if16.err},  {15'd0, m_err});
      check("rnd res16", if16.result,        m_res[15:0]);
      check("rnd ok8",   {15'd0, if8.ok},    {15'd0, m_ok()});
      check("rnd err8",  {15'd0, if8.err},   {15'd0, m_err});
      check("rnd res8",  {8'd0, if8.result}, {8'd0, m_res[7:0]});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
